// File: rtl/skinny_nf_pkg.sv
// skinny_nf_pkg: shared types, constants and round-constant update for the NullFresh SKINNY control
package skinny_nf_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SBOX, LIN, DONE} state_t;
  localparam int SKINNY_ROUNDS = 40;
  localparam int SBOX_STAGES = 4;
  localparam logic [5:0] RC_INIT = 6'h01;
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction
endpackage

// File: rtl/skinny_rc_lfsr.sv
// skinny_rc_lfsr: 6-bit SKINNY round-constant LFSR with load and step controls
module skinny_rc_lfsr
  import skinny_nf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  output logic [5:0] rc
);
  always_ff @(posedge clk)
    if (rst) rc <= '0;
    else if (init) rc <= RC_INIT;
    else if (step) rc <= rc_next(rc);
endmodule

// File: rtl/skinny_nf_round_ctrl.sv
// skinny_nf_round_ctrl: round/stage sequencer for the 3-share NullFresh SKINNY-128-128 core
module skinny_nf_round_ctrl #(
  parameter int ROUNDS = skinny_nf_pkg::SKINNY_ROUNDS,
  parameter int SBOX_STAGES = skinny_nf_pkg::SBOX_STAGES,
  parameter int RND_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   out_ack,
  output logic                   busy,
  output logic                   load_en,
  output logic [SBOX_STAGES-1:0] stage_en,
  output logic                   lin_en,
  output logic                   key_en,
  output logic [5:0]             rc,
  output logic [RND_W-1:0]       round_idx,
  output logic                   last_round,
  output logic                   done
);
  import skinny_nf_pkg::*;
  localparam int K_W = SBOX_STAGES > 1 ? $clog2(SBOX_STAGES) : 1;
  localparam logic [K_W-1:0] K_MAX = K_W'(SBOX_STAGES - 1);
  localparam logic [RND_W-1:0] R_MAX = RND_W'(ROUNDS - 1);
  state_t state;
  logic [K_W-1:0] k;
  logic rc_clr;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      k <= '0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? LOAD : IDLE;
        LOAD: begin
          state <= SBOX;
          k <= '0;
          round_idx <= '0;
        end
        SBOX: begin
          state <= (k == K_MAX) ? LIN : SBOX;
          k <= (k == K_MAX) ? k : k + 1'b1;
        end
        LIN: begin
          state <= last_round ? DONE : SBOX;
          k <= '0;
          round_idx <= last_round ? round_idx : round_idx + 1'b1;
        end
        DONE: begin
          state <= out_ack ? IDLE : DONE;
          round_idx <= out_ack ? '0 : round_idx;
        end
        default: state <= IDLE;
      endcase
    end
  // Outputs decode registered state only, so no input can glitch an enable
  assign busy = state == LOAD || state == SBOX || state == LIN;
  assign load_en = state == LOAD;
  assign stage_en = (state == SBOX) ? {{(SBOX_STAGES-1){1'b0}}, 1'b1} << k : '0;
  assign lin_en = state == LIN;
  assign key_en = lin_en;
  assign done = state == DONE;
  assign last_round = round_idx == R_MAX;
  assign rc_clr = rst || (state == DONE && out_ack);
  skinny_rc_lfsr u_rc (
    .clk (clk),
    .rst (rc_clr),
    .init(load_en),
    .step(lin_en && !last_round),
    .rc  (rc)
  );
endmodule

// File: tb/tb_skinny_nf_round_ctrl.sv
// tb_skinny_nf_round_ctrl: randomized self-checking bench against a cycle-indexed reference model
module tb_skinny_nf_round_ctrl;
  localparam int ROUNDS = 40;
  localparam int STAGES = 4;
  localparam int LAT = 2 + ROUNDS * (STAGES + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ack = 1'b0;
  logic busy, load_en, lin_en, key_en, last_round, done;
  logic [STAGES-1:0] stage_en;
  logic [5:0] rc, round_idx;
  int checks = 0, errors = 0;
  logic [5:0] rc_tab [ROUNDS] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

  skinny_nf_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .out_ack(out_ack), .busy(busy),
    .load_en(load_en), .stage_en(stage_en), .lin_en(lin_en), .key_en(key_en),
    .rc(rc), .round_idx(round_idx), .last_round(last_round), .done(done));

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_inv(input int c);
    checks++;
    if (int'(load_en) + $countones(stage_en) + int'(lin_en) > 1 || key_en !== lin_en) begin
      errors++;
      $display("FAIL excl cycle %0d: load=%b stage=%b lin=%b key=%b, required at most one enable and key==lin",
               c, load_en, stage_en, lin_en, key_en);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({load_en, stage_en, lin_en, key_en, busy, done, rc, round_idx, last_round} !== '0) begin
      errors++;
      $display("FAIL %s: load=%b stage=%b lin=%b key=%b busy=%b done=%b rc=%h rnd=%0d last=%b, required all zero",
               name, load_en, stage_en, lin_en, key_en, busy, done, rc, round_idx, last_round);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({load_en, stage_en, lin_en, busy, done, rc} !== '0) begin
      errors++;
      $display("FAIL %s: load=%b stage=%b lin=%b busy=%b done=%b rc=%h, required idle zeros",
               name, load_en, stage_en, lin_en, busy, done, rc);
    end
  endtask

  // c counts cycles after the edge that sampled start (LOAD is cycle 1)
  task automatic check_cycle(input int c);
    logic e_load, e_lin, e_busy, e_done;
    logic [STAGES-1:0] e_stage;
    int r, p;
    e_load = c == 1;
    e_lin = 0; e_stage = '0; e_busy = c < LAT; e_done = c >= LAT; r = ROUNDS - 1;
    if (c >= 2 && c < LAT) begin
      r = (c - 2) / (STAGES + 1);
      p = (c - 2) % (STAGES + 1);
      e_lin = p == STAGES;
      e_stage = (p < STAGES) ? STAGES'(1 << p) : '0;
    end
    checks++;
    if ({load_en, stage_en, lin_en, busy, done} !== {e_load, e_stage, e_lin, e_busy, e_done}) begin
      errors++;
      $display("FAIL ctrl cycle %0d: load=%b stage=%b lin=%b busy=%b done=%b, required %b %b %b %b %b",
               c, load_en, stage_en, lin_en, busy, done, e_load, e_stage, e_lin, e_busy, e_done);
    end
    if (c >= 2) begin
      checks++;
      if (rc !== rc_tab[r] || round_idx !== 6'(r)) begin
        errors++;
        $display("FAIL round cycle %0d: rc=%h rnd=%0d, required rc=%h rnd=%0d", c, rc, round_idx, rc_tab[r], r);
      end
    end
    if (c >= 2 && c < LAT) begin
      checks++;
      if (last_round !== (r == ROUNDS - 1)) begin
        errors++;
        $display("FAIL last_round cycle %0d: got %b, required %b", c, last_round, r == ROUNDS - 1);
      end
    end
    check_inv(c);
  endtask

  // One encryption; noise drives start/out_ack where both must be ignored; stop_at>0 aborts early
  task automatic run(input int ack_delay, input bit noise, input int stop_at);
    start = 1'b1;
    out_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    for (int c = 1; c <= LAT + ack_delay; c++) begin
      check_cycle(c);
      if (c == stop_at) return;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ack = (c < LAT) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : (c == LAT + ack_delay);
      tick();
    end
    start = 1'b0;
    out_ack = 1'b0;
    check_idle("idle_after_ack");
    out_ack = noise ? 1'b1 : 1'b0;
    tick();
    check_idle("idle_stays");
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; out_ack = 1'b1;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0; start = 1'b0;
    tick();
    check_zero("idle_ignores_ack");
    out_ack = 1'b0;
  endtask

  task automatic test_full_run();
    run(10, 1'b0, 0);
  endtask

  task automatic test_ignored_inputs();
    run($urandom_range(1, 6), 1'b1, 0);
  endtask

  task automatic test_mid_reset();
    run(0, 1'b1, 100);
    rst = 1'b1;
    start = 1'($urandom_range(0, 1));
    tick();
    check_zero("mid_reset");
    rst = 1'b0; start = 1'b0; out_ack = 1'b0;
    tick();
    check_zero("post_reset_idle");
    run(3, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run(0, 1'b0, 0);
    run(1, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_ignored_inputs();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
